// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
// Shared defaults for the parametrised register file with scoreboard:
//   XLEN_DEF      default data width
//   NREGS_DEF     default number of architectural registers
//   REG_ZERO_IDX  index of the hardwired-zero register
// Optional feature macro used by the files importing this package:
//   RF_WRITE_BYPASS_EN  same-edge writeback forwarding into reads/hazards
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 16;
  localparam int REG_ZERO_IDX = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of the decode/issue/writeback signals of the register file.
//   we, rd, write_data          writeback port
//   re, rs1, rs2                read request
//   read_data_1, read_data_2    registered read data
//   alloc_valid, alloc_rd       pending-write allocation from issue
//   rs_busy_1, rs_busy_2        per-port outstanding-writeback flags
//   hazard                      read blocked by an outstanding writeback
// master: pipeline side driving requests; slave: the register file.
// ---------------------------------------------------------------------------
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
);

  localparam int AW = $clog2(NREGS);

  logic            we;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
  logic            re;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] read_data_1;
  logic [XLEN-1:0] read_data_2;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_rd;
  logic            rs_busy_1;
  logic            rs_busy_2;
  logic            hazard;

  modport master (
    output we, rd, write_data, re, rs1, rs2, alloc_valid, alloc_rd,
    input  read_data_1, read_data_2, rs_busy_1, rs_busy_2, hazard
  );

  modport slave (
    input  we, rd, write_data, re, rs1, rs2, alloc_valid, alloc_rd,
    output read_data_1, read_data_2, rs_busy_1, rs_busy_2, hazard
  );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_sb_scoreboard (rf_scoreboard role)
// Pending-write scoreboard: one busy bit per architectural register.
//   clk, reset            clock, async active-low reset
//   we, rd                writeback completing (clears busy[rd])
//   alloc_valid, alloc_rd producer issued (sets busy[alloc_rd])
//   re, rs1, rs2          read request being checked
//   rs_busy_1/2, hazard   combinational hazard outputs
// Macro RF_WRITE_BYPASS_EN: a writeback completing this cycle already
// resolves the hazard on the register it writes.
// ---------------------------------------------------------------------------
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] rd,
  input  logic          alloc_valid,
  input  logic [AW-1:0] alloc_rd,
  input  logic          re,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs_busy_1,
  output logic          rs_busy_2,
  output logic          hazard
);

  localparam logic [AW-1:0] REG_ZERO = AW'(REG_ZERO_IDX);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic             rs_busy_1_s;
  logic             rs_busy_2_s;

  // Next busy vector: clear on writeback, then set on alloc so a newer producer wins.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      if (we && (rd == AW'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
      if (alloc_valid && (alloc_rd == AW'(i)) && (alloc_rd != REG_ZERO)) begin
        busy_next_s[i] = 1'b1;
      end else begin
        busy_next_s[i] = busy_next_s[i];
      end
    end
    busy_next_s[REG_ZERO_IDX] = 1'b0;
  end

  // Busy vector storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Per-port busy lookup, optionally masked by a completing writeback.
  always_comb begin
`ifdef RF_WRITE_BYPASS_EN
    rs_busy_1_s = busy_r[rs1] && !(we && (rd == rs1));
    rs_busy_2_s = busy_r[rs2] && !(we && (rd == rs2));
`else
    rs_busy_1_s = busy_r[rs1];
    rs_busy_2_s = busy_r[rs2];
`endif
  end

  assign rs_busy_1 = rs_busy_1_s;
  assign rs_busy_2 = rs_busy_2_s;
  assign hazard    = re && (rs_busy_1_s || rs_busy_2_s);

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Parametrised integer register file (2 registered read ports, 1 write
// port, x0 hardwired to zero) with a pending-write scoreboard.
//   clk    clock, all state on rising edge
//   reset  asynchronous active-low reset
//   bus    regfile_sb_if.slave: writeback, read, alloc and hazard signals
// Macro RF_WRITE_BYPASS_EN: a read capturing the register being written on
// the same edge returns the new write_data instead of the old contents.
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] REG_ZERO = AW'(REG_ZERO_IDX);

  logic [XLEN-1:0] regs_r [NREGS];
  logic [XLEN-1:0] rdata_1_r;
  logic [XLEN-1:0] rdata_2_r;
  logic [XLEN-1:0] rdata_1_s;
  logic [XLEN-1:0] rdata_2_s;
  logic            hazard_s;

  regfile_sb_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we          (bus.we),
    .rd          (bus.rd),
    .alloc_valid (bus.alloc_valid),
    .alloc_rd    (bus.alloc_rd),
    .re          (bus.re),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .rs_busy_1   (bus.rs_busy_1),
    .rs_busy_2   (bus.rs_busy_2),
    .hazard      (hazard_s)
  );

  assign bus.hazard = hazard_s;

  // Register storage; writes to x0 are dropped so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (bus.we && (bus.rd != REG_ZERO)) begin
      regs_r[bus.rd] <= bus.write_data;
    end else begin
      regs_r[REG_ZERO_IDX] <= {XLEN{1'b0}};
    end
  end

  // Read-port source selection (zero register, optional same-edge forward).
  always_comb begin
    rdata_1_s = regs_r[bus.rs1];
    rdata_2_s = regs_r[bus.rs2];
`ifdef RF_WRITE_BYPASS_EN
    if (bus.we && (bus.rd == bus.rs1)) begin
      rdata_1_s = bus.write_data;
    end else begin
      rdata_1_s = regs_r[bus.rs1];
    end
    if (bus.we && (bus.rd == bus.rs2)) begin
      rdata_2_s = bus.write_data;
    end else begin
      rdata_2_s = regs_r[bus.rs2];
    end
`endif
    if (bus.rs1 == REG_ZERO) begin
      rdata_1_s = {XLEN{1'b0}};
    end else begin
      rdata_1_s = rdata_1_s;
    end
    if (bus.rs2 == REG_ZERO) begin
      rdata_2_s = {XLEN{1'b0}};
    end else begin
      rdata_2_s = rdata_2_s;
    end
  end

  // Read data registers; a hazard stalls both ports together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_1_r <= {XLEN{1'b0}};
      rdata_2_r <= {XLEN{1'b0}};
    end else if (bus.re && !hazard_s) begin
      rdata_1_r <= rdata_1_s;
      rdata_2_r <= rdata_2_s;
    end else begin
      rdata_1_r <= rdata_1_r;
      rdata_2_r <= rdata_2_r;
    end
  end

  assign bus.read_data_1 = rdata_1_r;
  assign bus.read_data_2 = rdata_2_r;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Directed self-checking bench for regfile_sb at default parameters.
// Expected values are hand-computed; RF_WRITE_BYPASS_EN selects the
// expectations for same-edge write/read behaviour.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  regfile_sb_if #(.XLEN(32), .NREGS(16)) bus ();

  regfile_sb #(.XLEN(32), .NREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.we = 1'b0; bus.rd = 4'd0; bus.write_data = 32'h0;
    bus.re = 1'b0; bus.rs1 = 4'd5; bus.rs2 = 4'd0;
    bus.alloc_valid = 1'b0; bus.alloc_rd = 4'd0;

    // reset state
    repeat (2) tick();
    check("rst_rd1", bus.read_data_1, 32'h0);
    check("rst_rd2", bus.read_data_2, 32'h0);
    check("rst_busy1", {31'h0, bus.rs_busy_1}, 32'h0);
    check("rst_hazard", {31'h0, bus.hazard}, 32'h0);
    reset = 1'b1;

    // 1. fill x1..x15 with their index, read back in pairs
    for (int i = 1; i < 16; i++) begin
      bus.we = 1'b1; bus.rd = 4'(i); bus.write_data = 32'(i);
      tick();
    end
    bus.we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.re = 1'b1; bus.rs1 = 4'(2 * k); bus.rs2 = 4'(2 * k + 1);
      tick();
      check($sformatf("pair%0d_rd1", k), bus.read_data_1, 32'(2 * k));
      check($sformatf("pair%0d_rd2", k), bus.read_data_2, 32'(2 * k + 1));
    end
    bus.re = 1'b0;

    // 2. write to x0 is discarded
    bus.we = 1'b1; bus.rd = 4'd0; bus.write_data = 32'h9999_9999;
    tick();
    bus.we = 1'b0; bus.re = 1'b1; bus.rs1 = 4'd0; bus.rs2 = 4'd2;
    tick();
    check("x0_rd1", bus.read_data_1, 32'h0);
    check("x0_rd2", bus.read_data_2, 32'h2);
    bus.re = 1'b0;

    // 3. alloc x5, hazard stalls read, writeback resolves
    bus.alloc_valid = 1'b1; bus.alloc_rd = 4'd5; bus.rs1 = 4'd5;
    #1;
    check("alloc_not_yet", {31'h0, bus.rs_busy_1}, 32'h0);
    tick();
    bus.alloc_valid = 1'b0;
    #1;
    check("alloc_busy1", {31'h0, bus.rs_busy_1}, 32'h1);
    bus.re = 1'b1; bus.rs1 = 4'd5; bus.rs2 = 4'd1;
    #1;
    check("alloc_hazard", {31'h0, bus.hazard}, 32'h1);
    tick();
    check("stall_rd1", bus.read_data_1, 32'h0);
    check("stall_rd2", bus.read_data_2, 32'h2);
    bus.re = 1'b0; bus.we = 1'b1; bus.rd = 4'd5; bus.write_data = 32'hAB;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("wb_busy1_same", {31'h0, bus.rs_busy_1}, 32'h0);
`else
    check("wb_busy1_same", {31'h0, bus.rs_busy_1}, 32'h1);
`endif
    tick();
    bus.we = 1'b0;
    #1;
    check("wb_busy1_after", {31'h0, bus.rs_busy_1}, 32'h0);
    bus.re = 1'b1; bus.rs1 = 4'd5; bus.rs2 = 4'd1;
    tick();
    check("wb_rd1", bus.read_data_1, 32'hAB);
    check("wb_rd2", bus.read_data_2, 32'h1);
    bus.re = 1'b0;

    // 4. same-edge alloc and writeback of x7: set wins
    bus.alloc_valid = 1'b1; bus.alloc_rd = 4'd7;
    bus.we = 1'b1; bus.rd = 4'd7; bus.write_data = 32'h77;
    tick();
    bus.alloc_valid = 1'b0; bus.we = 1'b0; bus.rs1 = 4'd7;
    #1;
    check("setwins_busy", {31'h0, bus.rs_busy_1}, 32'h1);
    bus.we = 1'b1; bus.rd = 4'd7; bus.write_data = 32'h70;
    tick();
    bus.we = 1'b0;
    #1;
    check("clear_busy", {31'h0, bus.rs_busy_1}, 32'h0);
    bus.re = 1'b1; bus.rs1 = 4'd7; bus.rs2 = 4'd0;
    tick();
    check("x7_rd1", bus.read_data_1, 32'h70);
    check("x7_rd2", bus.read_data_2, 32'h0);
    bus.re = 1'b0;

    // 5. same-edge write x3 and read rs2=3
    bus.we = 1'b1; bus.rd = 4'd3; bus.write_data = 32'h55;
    bus.re = 1'b1; bus.rs1 = 4'd1; bus.rs2 = 4'd3;
    tick();
    check("byp_rd1", bus.read_data_1, 32'h1);
`ifdef RF_WRITE_BYPASS_EN
    check("byp_rd2", bus.read_data_2, 32'h55);
`else
    check("byp_rd2", bus.read_data_2, 32'h3);
`endif
    bus.we = 1'b0;
    tick();
    check("x3_new_rd2", bus.read_data_2, 32'h55);
    bus.re = 1'b0;

    // 6. reset mid-sequence with x9 busy
    bus.alloc_valid = 1'b1; bus.alloc_rd = 4'd9;
    tick();
    bus.alloc_valid = 1'b0; bus.re = 1'b1; bus.rs1 = 4'd9; bus.rs2 = 4'd3;
    #1;
    check("pre_rst_busy1", {31'h0, bus.rs_busy_1}, 32'h1);
    check("pre_rst_hazard", {31'h0, bus.hazard}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rd1", bus.read_data_1, 32'h0);
    check("mid_rst_rd2", bus.read_data_2, 32'h0);
    check("mid_rst_busy1", {31'h0, bus.rs_busy_1}, 32'h0);
    check("mid_rst_hazard", {31'h0, bus.hazard}, 32'h0);
    #2;
    reset = 1'b1;
    bus.re = 1'b0; bus.we = 1'b1; bus.rd = 4'd9; bus.write_data = 32'h1234;
    tick();
    bus.we = 1'b0;
    #1;
    check("post_rst_busy1", {31'h0, bus.rs_busy_1}, 32'h0);
    bus.re = 1'b1; bus.rs1 = 4'd9; bus.rs2 = 4'd3;
    tick();
    check("post_rst_x9", bus.read_data_1, 32'h1234);
    check("post_rst_x3", bus.read_data_2, 32'h0);
    bus.re = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_sb
